// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the sequenced 16x16 multiplier: state codes, flag
// bit positions and the 8x8 multiplier request type.
package mult_sequencer_pkg;

  localparam logic [2:0] MS_IDLE = 3'd0;
  localparam logic [2:0] MS_PP0  = 3'd1;
  localparam logic [2:0] MS_PP1  = 3'd2;
  localparam logic [2:0] MS_PP2  = 3'd3;
  localparam logic [2:0] MS_PP3  = 3'd4;
  localparam logic [2:0] MS_DONE = 3'd5;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_RSVD = 2;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } mul_req_t;

  function automatic logic [2:0] mk_flags32(input logic [31:0] v);
    logic [2:0] f;
    f            = '0;
    f[FLAG_ZERO] = (v == 32'd0);
    f[FLAG_NEG]  = v[31];
    f[FLAG_RSVD] = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/mult_sequencer_mul8.sv
// Existing 8x8 unsigned combinational multiplier with output enable and ALU flags.
module mult_sequencer_mul8
  import mult_sequencer_pkg::*;
(
  input  mul_req_t    i_req,
  input  logic        i_oe,
  output logic [15:0] o_pp,
  output logic [2:0]  o_flags
);

  logic [15:0] w_pp;
  logic [2:0]  w_flags;

  assign w_pp = 16'(i_req.a) * 16'(i_req.b);

  always_comb begin
    w_flags            = '0;
    w_flags[FLAG_ZERO] = (w_pp == 16'd0);
    w_flags[FLAG_NEG]  = w_pp[15];
  end

  assign o_pp    = i_oe ? w_pp    : '0;
  assign o_flags = i_oe ? w_flags : '0;

endmodule

// File: rtl/mult_sequencer.sv
// 16x16 unsigned multiply sequenced over one 8x8 multiplier: four partial
// products are shifted and accumulated, with a start/busy/done handshake.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter bit FAST_8BIT = 1'b1
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        oe,
  output logic        busy,
  output logic        done,
  output wire  [31:0] product,
  output wire  [2:0]  flags
);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [31:0] r_acc;
  mul_req_t    w_req;
  logic [15:0] w_pp;
  logic [31:0] w_pp_sh;
  logic [2:0]  w_unused_mul_flags;
  logic        w_accept;
  logic        w_fast;
  logic [2:0]  w_flags;

  assign busy     = (r_state == MS_PP0) || (r_state == MS_PP1) ||
                    (r_state == MS_PP2) || (r_state == MS_PP3);
  assign done     = (r_state == MS_DONE);
  assign w_accept = start && ((r_state == MS_IDLE) || (r_state == MS_DONE));
  assign w_fast   = FAST_8BIT && (r_a[15:8] == 8'd0) && (r_b[15:8] == 8'd0);

  // Operand select and partial-product alignment both follow the current state
  always_comb begin
    w_req   = '{a: r_a[7:0], b: r_b[7:0]};
    w_pp_sh = {16'd0, w_pp};
    case (r_state)
      MS_PP1: begin
        w_req.a = r_a[15:8];
        w_pp_sh = {8'd0, w_pp, 8'd0};
      end
      MS_PP2: begin
        w_req.b = r_b[15:8];
        w_pp_sh = {8'd0, w_pp, 8'd0};
      end
      MS_PP3: begin
        w_req   = '{a: r_a[15:8], b: r_b[15:8]};
        w_pp_sh = {w_pp, 16'd0};
      end
      default: ;
    endcase
  end

  mult_sequencer_mul8 u_mul8 (
    .i_req   (w_req),
    .i_oe    (1'b1),
    .o_pp    (w_pp),
    .o_flags (w_unused_mul_flags)
  );

  always_comb begin
    w_next = MS_IDLE;
    case (r_state)
      MS_IDLE: w_next = w_accept ? MS_PP0 : MS_IDLE;
      MS_PP0:  w_next = w_fast ? MS_DONE : MS_PP1;
      MS_PP1:  w_next = MS_PP2;
      MS_PP2:  w_next = MS_PP3;
      MS_PP3:  w_next = MS_DONE;
      MS_DONE: w_next = w_accept ? MS_PP0 : MS_IDLE;
      default: w_next = MS_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state <= MS_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= op_a;
        r_b   <= op_b;
        r_acc <= '0;
      end else if (r_state == MS_PP0) begin
        r_acc <= w_pp_sh;
      end else if (busy) begin
        r_acc <= r_acc + w_pp_sh;
      end
    end
  end

  assign w_flags = mk_flags32(r_acc);

  // Bus is released whenever oe is low, independent of the sequencer state
  assign product = oe ? r_acc   : 32'bz;
  assign flags   = oe ? w_flags : 3'bz;

endmodule

// File: tb/tb_mult_sequencer.sv
// Randomized and directed check of mult_sequencer (fast and full-path builds)
// against a cycle-level arithmetic reference model.
module tb_mult_sequencer;

  logic        clock;
  logic        nreset;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        oe;
  logic [1:0]  w_busy;
  logic [1:0]  w_done;
  wire  [31:0] w_prod_f;
  wire  [31:0] w_prod_s;
  wire  [2:0]  w_flags_f;
  wire  [2:0]  w_flags_s;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mult_sequencer #(.FAST_8BIT(1'b1)) dut_f (
    .clock(clock), .nreset(nreset), .start(start), .op_a(op_a), .op_b(op_b),
    .oe(oe), .busy(w_busy[0]), .done(w_done[0]), .product(w_prod_f), .flags(w_flags_f)
  );

  mult_sequencer #(.FAST_8BIT(1'b0)) dut_s (
    .clock(clock), .nreset(nreset), .start(start), .op_a(op_a), .op_b(op_b),
    .oe(oe), .busy(w_busy[1]), .done(w_done[1]), .product(w_prod_s), .flags(w_flags_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: index 0 = fast build, index 1 = full-path build
  bit          m_act  [2];
  bit          m_done [2];
  int          m_k    [2];
  logic [31:0] m_acc  [2];
  logic [15:0] m_a    [2];
  logic [15:0] m_b    [2];

  function automatic logic [31:0] term(input logic [15:0] a, input logic [15:0] b, input int k);
    logic [31:0] al, ah, bl, bh;
    al = 32'(a[7:0]); ah = 32'(a[15:8]);
    bl = 32'(b[7:0]); bh = 32'(b[15:8]);
    case (k)
      0:       return al * bl;
      1:       return (ah * bl) * 256;
      2:       return (al * bh) * 256;
      default: return (ah * bh) * 65536;
    endcase
  endfunction

  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0; m_done[i] <= 1'b0; m_k[i] <= 0;
        m_acc[i] <= '0;   m_a[i] <= '0;      m_b[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_act[i]) begin
          m_done[i] <= 1'b0;
          if (start) begin
            m_act[i] <= 1'b1; m_k[i] <= 0; m_acc[i] <= '0;
            m_a[i] <= op_a;   m_b[i] <= op_b;
          end
        end else begin
          m_acc[i] <= m_acc[i] + term(m_a[i], m_b[i], m_k[i]);
          m_k[i]   <= m_k[i] + 1;
          if (m_k[i] == 3 || (i == 0 && m_a[i][15:8] == 8'd0 && m_b[i][15:8] == 8'd0)) begin
            m_act[i]  <= 1'b0;
            m_done[i] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A released bus reads as Z in four-state simulators and as 0 in two-state ones
  task automatic chk_off(input string name, input bit ok, input logic [31:0] act);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h, expected released bus (t=%0t)", name, act, $time);
    end
  endtask

  task automatic cmp_dut(input int i, input logic b, input logic d, input logic [31:0] p,
                         input logic [2:0] f, input bit poff, input bit foff);
    chk($sformatf("busy[%0d]", i), 32'(b), 32'(m_act[i]));
    chk($sformatf("done[%0d]", i), 32'(d), 32'(m_done[i]));
    if (oe) begin
      chk($sformatf("product[%0d]", i), p, m_acc[i]);
      chk($sformatf("flags[%0d]", i), 32'(f), 32'({1'b0, m_acc[i][31], m_acc[i] == 32'd0}));
    end else begin
      chk_off($sformatf("product_off[%0d]", i), poff, p);
      chk_off($sformatf("flags_off[%0d]", i), foff, 32'(f));
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (chk_en) begin
      cmp_dut(0, w_busy[0], w_done[0], w_prod_f, w_flags_f,
              (w_prod_f === 32'bz) || (w_prod_f === 32'h0),
              (w_flags_f === 3'bz) || (w_flags_f === 3'b0));
      cmp_dut(1, w_busy[1], w_done[1], w_prod_s, w_flags_s,
              (w_prod_s === 32'bz) || (w_prod_s === 32'h0),
              (w_flags_s === 3'bz) || (w_flags_s === 3'b0));
    end
  end

  // Launch one multiply, drop start after the accepting edge, record when
  // each build pulses done (cycles counted from the accepting edge as 1).
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         output int lf, output int ls, output int bs,
                         output logic [31:0] pf, output logic [31:0] ps,
                         output logic [2:0] ff, output logic [2:0] fs);
    @(negedge clock);
    op_a = a; op_b = b; start = 1'b1;
    lf = 0; ls = 0; bs = 0; pf = '0; ps = '0; ff = '0; fs = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
      if (w_busy[1]) bs++;
      if (w_done[0] && lf == 0) begin lf = c; pf = w_prod_f; ff = w_flags_f; end
      if (w_done[1] && ls == 0) begin ls = c; ps = w_prod_s; fs = w_flags_s; end
      @(negedge clock);
      start = 1'b0;
    end
  endtask

  initial begin
    int lf, ls, bs, n;
    logic [31:0] pf, ps;
    logic [2:0]  ff, fs;

    nreset = 1'b0; start = 1'b0; op_a = '0; op_b = '0; oe = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", 32'(w_busy), 32'd0);
    chk("reset_done", 32'(w_done), 32'd0);
    chk("reset_prod_f", w_prod_f, 32'd0);
    chk("reset_flags_f", 32'(w_flags_f), 32'd1);
    @(negedge clock);
    nreset = 1'b1;
    chk_en = 1'b1;

    run_mul(16'h1234, 16'h5678, lf, ls, bs, pf, ps, ff, fs);
    chk("t1_lat_f", 32'(lf), 32'd5);
    chk("t1_lat_s", 32'(ls), 32'd5);
    chk("t1_prod", ps, 32'h06260060);
    chk("t1_flags", 32'(fs), 32'd0);

    run_mul(16'hFFFF, 16'hFFFF, lf, ls, bs, pf, ps, ff, fs);
    chk("t2_prod_f", pf, 32'hFFFE0001);
    chk("t2_prod_s", ps, 32'hFFFE0001);
    chk("t2_flags", 32'(fs), 32'b010);
    chk("t2_busy_cycles", 32'(bs), 32'd4);

    run_mul(16'h0012, 16'h0034, lf, ls, bs, pf, ps, ff, fs);
    chk("t3_lat_fast", 32'(lf), 32'd2);
    chk("t3_lat_full", 32'(ls), 32'd5);
    chk("t3_prod_f", pf, 32'h000003A8);
    chk("t3_prod_s", ps, 32'h000003A8);

    run_mul(16'h0000, 16'hABCD, lf, ls, bs, pf, ps, ff, fs);
    chk("t4_prod", ps, 32'd0);
    chk("t4_flags", 32'(fs), 32'b001);
    @(negedge clock); oe = 1'b0;
    #1;
    chk_off("t4_prod_z", (w_prod_s === 32'bz) || (w_prod_s === 32'h0), w_prod_s);
    chk_off("t4_flags_z", (w_flags_s === 3'bz) || (w_flags_s === 3'b0), 32'(w_flags_s));
    @(negedge clock); oe = 1'b1;

    // start pulsed during PP1 must be ignored
    @(negedge clock); op_a = 16'h1111; op_b = 16'h2222; start = 1'b1;
    @(posedge clock); #1;
    @(negedge clock); start = 1'b0;
    @(posedge clock); #1;
    @(negedge clock); start = 1'b1; op_a = 16'hAAAA; op_b = 16'hBBBB;
    n = 0;
    while (!w_done[1] && n < 10) begin
      @(posedge clock); #1; n++;
      @(negedge clock); start = 1'b0;
    end
    chk("t5a_done_seen", 32'(w_done[1]), 32'd1);
    chk("t5a_prod", w_prod_s, 32'h02468642);

    // start held through DONE: second multiply accepted back-to-back
    repeat (2) @(negedge clock);
    op_a = 16'h00FF; op_b = 16'h0101; start = 1'b1;
    n = 0;
    while (!w_done[1] && n < 10) begin
      @(posedge clock); #1; n++;
    end
    chk("t5b_lat_first", 32'(n), 32'd5);
    chk("t5b_prod_first", w_prod_s, 32'h0000FFFF);
    @(negedge clock); op_a = 16'h0003; op_b = 16'h0005;
    @(posedge clock); #1;
    chk("t5b_busy_again", 32'(w_busy), 32'b11);
    @(negedge clock); start = 1'b0;
    lf = 0; ls = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
      if (w_done[0] && lf == 0) begin lf = c; pf = w_prod_f; end
      if (w_done[1] && ls == 0) begin ls = c; ps = w_prod_s; end
    end
    chk("t5b_lat2_f", 32'(lf), 32'd1);
    chk("t5b_lat2_s", 32'(ls), 32'd4);
    chk("t5b_prod2_f", pf, 32'd15);
    chk("t5b_prod2_s", ps, 32'd15);

    // reset during PP2 aborts at once and never produces done
    @(negedge clock); op_a = 16'h1234; op_b = 16'h5678; start = 1'b1;
    @(posedge clock); #1;
    @(negedge clock); start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); nreset = 1'b0;
    #1;
    chk("t6_busy", 32'(w_busy), 32'd0);
    chk("t6_done", 32'(w_done), 32'd0);
    chk("t6_prod", w_prod_s, 32'd0);
    @(negedge clock); nreset = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      if (w_done != 2'b00) n++;
    end
    chk("t6_no_done", 32'(n), 32'd0);
    run_mul(16'h00FF, 16'h00FF, lf, ls, bs, pf, ps, ff, fs);
    chk("t6_after_lat_f", 32'(lf), 32'd2);
    chk("t6_after_prod_f", pf, 32'h0000FE01);
    chk("t6_after_prod_s", ps, 32'h0000FE01);

    // Random traffic; the per-cycle model comparison does the checking
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      start = ($urandom_range(0, 2) == 0);
      op_a  = 16'($urandom);
      op_b  = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        op_a[15:8] = 8'd0;
        op_b[15:8] = 8'd0;
      end
      oe     = ($urandom_range(0, 3) != 0);
      nreset = ($urandom_range(0, 149) != 0);
    end
    @(negedge clock); nreset = 1'b1; start = 1'b0; oe = 1'b1;
    repeat (8) @(posedge clock);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
